// File: rtl/imul_int_mul_varlat_param_pkg.sv
// Shared types for the variable-latency integer multiplier:
// FSM state encoding, operation encodings and signedness helpers.
package imul_varlat_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_t;

  // Operand a is two's complement for MULH and MULHSU.
  function automatic logic a_is_signed(op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // Operand b is two's complement only for MULH.
  function automatic logic b_is_signed(op_t op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/imul_int_mul_varlat_param_if.sv
// Request/response handshake bundle of the multiplier.
// master = requester side, slave = multiplier side.
interface imul_int_mul_varlat_param_if #(
  parameter int NBITS = 32
);
  logic                 recv_val;
  logic                 recv_rdy;
  logic [2*NBITS+1:0]   recv_msg;
  logic                 send_val;
  logic                 send_rdy;
  logic [NBITS-1:0]     send_msg;

  modport master (
    output recv_val, recv_msg, send_rdy,
    input  recv_rdy, send_val, send_msg
  );

  modport slave (
    input  recv_val, recv_msg, send_rdy,
    output recv_rdy, send_val, send_msg
  );
endinterface

// File: rtl/imul_int_mul_varlat_param_calc_shamt.sv
// Shift-amount generator for one iteration of the shift-add loop.
// With IMUL_VARLAT_SKIP_ZEROS_EN defined, runs of zero bits in the low
// byte of b are skipped in a single step (up to 8 bits); otherwise
// every step shifts by exactly one.
module imul_varlat_calc_shamt (
  input  logic [7:0] b,
  output logic [3:0] shamt
);

`ifdef IMUL_VARLAT_SKIP_ZEROS_EN
  // Trailing-zero count of the low byte, 8 when the byte is empty;
  // a set LSB means an add is pending, so only advance by one.
  always_comb begin
    shamt = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) shamt = 4'(i);
    end
    if (b[0]) shamt = 4'd1;
  end
`else
  logic unused_b;
  assign unused_b = ^b;

  // Plain radix-2 iteration: one bit per step.
  always_comb begin
    shamt = 4'd1;
  end
`endif

endmodule

// File: rtl/imul_int_mul_varlat_param.sv
// Variable-latency iterative integer multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are converted to magnitudes on accept, multiplied with a
// shift-add loop that ends as soon as the remaining multiplier is zero,
// and the sign is reapplied on the way out.
// Optional zero-skipping is enabled by defining IMUL_VARLAT_SKIP_ZEROS_EN.
module imul_int_mul_varlat_param
  import imul_varlat_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic clk,
  input  logic reset_n,
  imul_int_mul_varlat_param_if.slave io
);

  localparam int W2 = 2 * NBITS;

  state_t            state;
  op_t               op_reg;
  logic              neg;
  logic [W2-1:0]     a_reg;
  logic [NBITS-1:0]  b_reg;
  logic [W2-1:0]     result;
  logic              idle_q;
  logic              send_val_q;
  logic [3:0]        shamt;

  op_t               req_op;
  logic [NBITS-1:0]  req_a;
  logic [NBITS-1:0]  req_b;
  logic              a_neg;
  logic              b_neg;
  logic [NBITS-1:0]  a_mag;
  logic [NBITS-1:0]  b_mag;
  logic [W2-1:0]     full;
  logic [NBITS-1:0]  sel;

  assign req_op = op_t'(io.recv_msg[W2+1 -: 2]);
  assign req_a  = io.recv_msg[W2-1 -: NBITS];
  assign req_b  = io.recv_msg[NBITS-1:0];

  // Magnitude conversion; -(-2^(NBITS-1)) wraps to 2^(NBITS-1), which is
  // exactly the right unsigned magnitude.
  assign a_neg = a_is_signed(req_op) && req_a[NBITS-1];
  assign b_neg = b_is_signed(req_op) && req_b[NBITS-1];
  assign a_mag = a_neg ? -req_a : req_a;
  assign b_mag = b_neg ? -req_b : req_b;

  imul_varlat_calc_shamt u_calc_shamt (
    .b     (b_reg[7:0]),
    .shamt (shamt)
  );

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op_reg     <= OP_MUL;
      neg        <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result     <= '0;
      idle_q     <= 1'b1;
      send_val_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.recv_val) begin
            op_reg <= req_op;
            neg    <= a_neg ^ b_neg;
            a_reg  <= {{NBITS{1'b0}}, a_mag};
            b_reg  <= b_mag;
            result <= '0;
            idle_q <= 1'b0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (b_reg == '0) begin
            send_val_q <= 1'b1;
            state      <= S_DONE;
          end else begin
            if (b_reg[0]) result <= result + a_reg;
            a_reg <= a_reg << shamt;
            b_reg <= b_reg >> shamt;
          end
        end
        S_DONE: begin
          if (io.send_rdy) begin
            send_val_q <= 1'b0;
            idle_q     <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          send_val_q <= 1'b0;
          idle_q     <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  // Sign reapplied over the full product, then the requested half picked.
  always_comb begin
    full = neg ? -result : result;
    sel  = (op_reg == OP_MUL) ? full[NBITS-1:0] : full[W2-1:NBITS];
  end

  // Ready is masked by reset so it stays low while reset is held and
  // rises immediately on release.
  assign io.recv_rdy = idle_q & reset_n;
  assign io.send_val = send_val_q;
  assign io.send_msg = send_val_q ? sel : '0;

endmodule

// File: tb/tb_imul_int_mul_varlat_param.sv
// Directed bench for imul_int_mul_varlat_param (NBITS=32).
// Latency expectations follow IMUL_VARLAT_SKIP_ZEROS_EN when defined.
module tb_imul_int_mul_varlat_param;
  import imul_varlat_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imul_int_mul_varlat_param_if #(.NBITS(32)) bus ();

  imul_int_mul_varlat_param #(.NBITS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus.slave)
  );

`ifdef IMUL_VARLAT_SKIP_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat_d;
    int          lat_s;
  } vec_t;

  // Issue one request (called at a negedge) and wait for the response.
  // lat = -1 when either handshake never happens within its bound.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic [31:0] msg);
    int t0;
    int n;
    lat = -1;
    msg = '0;
    n = 0;
    while (bus.recv_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.recv_rdy !== 1'b1) return;
    bus.recv_val = 1'b1;
    bus.recv_msg = {op, a, b};
    t0 = cyc;
    @(negedge clk);
    bus.recv_val = 1'b0;
    bus.recv_msg = '0;
    n = 0;
    while (bus.send_val !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.send_val === 1'b1) begin
      lat = cyc - t0;
      msg = bus.send_msg;
    end
  endtask

  task automatic test_reset();
    bus.recv_val = 1'b0;
    bus.recv_msg = '0;
    bus.send_rdy = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.recv_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_recv_rdy: got %b expected 0", bus.recv_rdy);
    end
    checks++;
    if (bus.send_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_send_val: got %b expected 0", bus.send_val);
    end
    checks++;
    if (bus.send_msg !== 32'h0) begin
      errors++;
      $display("FAIL reset_send_msg: got %h expected 00000000", bus.send_msg);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.recv_rdy !== 1'b1) begin
      errors++;
      $display("FAIL release_recv_rdy: got %b expected 1", bus.recv_rdy);
    end
    @(negedge clk);
  endtask

  task automatic test_ops();
    vec_t v[11];
    int lat;
    int exp_lat;
    logic [31:0] msg;
    v[0]  = '{OP_MUL,    32'd3,        32'd5,        32'd15,       5,  5};
    v[1]  = '{OP_MUL,    32'd123,      32'd0,        32'd0,        2,  2};
    v[2]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3,  3};
    v[3]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 7};
    v[4]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 34};
    v[5]  = '{OP_MULHSU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 34};
    v[6]  = '{OP_MUL,    32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 5,  5};
    v[7]  = '{OP_MUL,    32'd1,        32'h80000000, 32'h80000000, 34, 7};
    v[8]  = '{OP_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 5,  5};
    v[9]  = '{OP_MULHSU, 32'd3,        32'h80000000, 32'h00000001, 34, 7};
    v[10] = '{OP_MULHU,  32'h80000000, 32'd4,        32'h00000002, 5,  4};
    bus.send_rdy = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, msg);
      exp_lat = SKIP ? v[i].lat_s : v[i].lat_d;
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL op%0d_latency: got %0d expected %0d", i, lat, exp_lat);
      end
      checks++;
      if (msg !== v[i].exp) begin
        errors++;
        $display("FAIL op%0d_result: got %h expected %h", i, msg, v[i].exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] msg;
    bus.send_rdy = 1'b0;
    run_op(OP_MUL, 32'd3, 32'd5, lat, msg);
    checks++;
    if (lat != 5 || msg !== 32'd15) begin
      errors++;
      $display("FAIL bp_first: got lat %0d msg %h expected lat 5 msg 0000000f", lat, msg);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.send_val !== 1'b1 || bus.send_msg !== 32'd15 || bus.recv_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got val %b msg %h rdy %b expected val 1 msg 0000000f rdy 0",
                 i, bus.send_val, bus.send_msg, bus.recv_rdy);
      end
    end
    bus.send_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.send_val !== 1'b0 || bus.recv_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got val %b rdy %b expected val 0 rdy 1",
               bus.send_val, bus.recv_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int t0;
    int n;
    logic [31:0] msg;
    bus.send_rdy = 1'b1;
    run_op(OP_MUL, 32'd6, 32'd7, lat, msg);
    checks++;
    if (lat != 5 || msg !== 32'd42) begin
      errors++;
      $display("FAIL b2b_first: got lat %0d msg %h expected lat 5 msg 0000002a", lat, msg);
    end
    // Request presented while the response is being taken.
    bus.recv_val = 1'b1;
    bus.recv_msg = {OP_MUL, 32'd10, 32'd11};
    checks++;
    if (bus.recv_rdy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rdy_in_done: got %b expected 0", bus.recv_rdy);
    end
    @(negedge clk);
    checks++;
    if (bus.recv_rdy !== 1'b1 || bus.send_val !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got rdy %b val %b expected rdy 1 val 0",
               bus.recv_rdy, bus.send_val);
    end
    t0 = cyc;
    @(negedge clk);
    bus.recv_val = 1'b0;
    bus.recv_msg = '0;
    n = 0;
    while (bus.send_val !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = (bus.send_val === 1'b1) ? cyc - t0 : -1;
    checks++;
    if (lat != 6 || bus.send_msg !== 32'd110) begin
      errors++;
      $display("FAIL b2b_second: got lat %0d msg %h expected lat 6 msg 0000006e",
               lat, bus.send_msg);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [31:0] msg;
    bus.send_rdy = 1'b1;
    // Reset during CALC.
    bus.recv_val = 1'b1;
    bus.recv_msg = {OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF};
    @(negedge clk);
    bus.recv_val = 1'b0;
    bus.recv_msg = '0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.send_val !== 1'b0 || bus.recv_rdy !== 1'b0 || bus.send_msg !== 32'h0) begin
      errors++;
      $display("FAIL rst_calc_outputs: got val %b rdy %b msg %h expected 0 0 00000000",
               bus.send_val, bus.recv_rdy, bus.send_msg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.recv_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_calc_release_rdy: got %b expected 1", bus.recv_rdy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.send_val === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_calc_stale: got %0d response cycles expected 0", seen);
    end
    run_op(OP_MUL, 32'd3, 32'd5, lat, msg);
    checks++;
    if (lat != 5 || msg !== 32'd15) begin
      errors++;
      $display("FAIL rst_calc_after: got lat %0d msg %h expected lat 5 msg 0000000f", lat, msg);
    end
    @(negedge clk);
    // Reset while holding a response in DONE.
    bus.send_rdy = 1'b0;
    run_op(OP_MUL, 32'd9, 32'd0, lat, msg);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL rst_done_setup: got lat %0d expected 2", lat);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.send_val !== 1'b0) begin
      errors++;
      $display("FAIL rst_done_val: got %b expected 0", bus.send_val);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.send_rdy = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.send_val === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_done_stale: got %0d response cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imul_int_mul_varlat_param.md
IMUL_INT_MUL_VARLAT_PARAM -- requirements
Module: imul_int_mul_varlat_param

Interface
REQ-001 SHALL have parameter NBITS, default 32, operand width (>=8, even).
REQ-002 SHALL have clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have recv_val  input  1  request valid.
REQ-005 SHALL have recv_rdy  output  1  request ready.
REQ-006 SHALL have recv_msg  input  2*NBITS+2  {op[1:0], a[NBITS-1:0], b[NBITS-1:0]}, with op in the MSBs.
REQ-007 SHALL have send_val  output  1  response valid.
REQ-008 SHALL have send_rdy  input  1  response ready.
REQ-009 SHALL have send_msg  output  NBITS  result; all-zero whenever send_val=0.

Function
REQ-010 SHALL decode op as: 0 MUL (low half of product), 1 MULH (signed x signed, high half), 2 MULHSU (signed a x unsigned b, high half), 3 MULHU (unsigned x unsigned, high half).
REQ-011 SHALL implement FSM states IDLE, CALC and DONE: IDLE->CALC on recv_val&&recv_rdy; CALC->DONE when the b register is zero; DONE->IDLE on send_val&&send_rdy.
REQ-012 SHALL assert recv_rdy only in IDLE and send_val only in DONE.
REQ-013 On accept, SHALL load a and b as magnitudes: negate an operand only if it is treated as signed and its MSB=1.
REQ-014 On accept, SHALL latch neg = sign(a)^sign(b), counting only operands treated as signed.
REQ-015 On accept, SHALL clear the 2*NBITS result register; the a register is 2*NBITS wide, zero-extended.
REQ-016 Each CALC cycle with b!=0, SHALL add a to result when b[0]=1, then shift a left and b right by shamt.
REQ-017 SHALL set shamt = 1 when b[0]=1.
REQ-018 When b[0]=0, SHALL set shamt per the REQ-026 configuration.
REQ-019 SHALL make send_msg combinational from the result register: negate all 2*NBITS bits if neg=1, then select the low half (MUL) or high half (others); the result SHALL be truncated modulo 2^(2*NBITS).
REQ-020 Latency: if accepted in cycle T, SHALL assert send_val in cycle T+2+S, S = number of shift steps; b=0 gives T+2.
REQ-021 Under backpressure (send_rdy=0), SHALL hold DONE with send_msg stable.
REQ-022 SHALL NOT accept a request in the same cycle as a send; minimum occupancy 3 cycles per operation.
REQ-023 SHALL handle the most-negative operand (-2^(NBITS-1)) correctly; its magnitude is 2^(NBITS-1) unsigned.

Reset
REQ-024 While reset_n=0 (asynchronously), SHALL force state IDLE and clear result, neg, a and b, with recv_rdy=0, send_val=0 and send_msg=0.
REQ-025 Reset mid-CALC or mid-DONE SHALL discard the operation without emitting a response; recv_rdy=1 in the first cycle after release.

Configuration
REQ-026 SHALL support macro IMUL_VARLAT_SKIP_ZEROS_EN; when it is defined, shamt for b[0]=0 is the trailing-zero count of b[7:0], or 8 if b[7:0]=0.
REQ-027 When IMUL_VARLAT_SKIP_ZEROS_EN is undefined, shamt SHALL always be 1 (S = index of highest set bit of |b| + 1).

Structure
REQ-028 SHALL place the state enum, the op encodings (MUL/MULH/MULHSU/MULHU) and the state width in package imul_varlat_pkg.
REQ-029 SHALL implement shamt generation in sub-module imul_varlat_calc_shamt (8-bit in, 4-bit out), instantiated once.

Verification
REQ-030 SHALL verify: NBITS=32, MUL a=3 b=5 -> send_msg=15; b=0 case -> response in cycle T+2 with value 0.
REQ-031 SHALL verify: MULH a=-1 b=-1 -> 0x00000000; MULH a=0x80000000 b=0x80000000 -> 0x40000000; MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 SHALL verify: MULHSU a=-2 b=0xFFFFFFFF -> 0xFFFFFFFE; MUL a=-7 b=6 -> 0xFFFFFFD6.
REQ-033 SHALL verify: b=0x80000000 MUL -> response at T+34 without the macro and T+7 with it (shamt sequence 8,8,8,7,1).
REQ-034 SHALL verify: hold send_rdy=0 for 5 cycles -> send_val and send_msg stable, recv_rdy=0; then send_rdy=1 -> IDLE next cycle.
REQ-035 SHALL verify: pulse reset_n low mid-CALC -> send_val=0 immediately, no stale response; a new request after release returns the correct product.
